// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: merges the pipeline result (port A) and the mul/div result
// (port B, buffered in a 2-entry in-order FIFO) into a single registered
// GPR write port. Port A has priority. The FIFO head is protected from
// starvation by a_stall. pend reports GPRs that have a write in flight.
// Optional feature macro: REGFILE_WB_BYPASS_EN. When it is defined, a B
// transfer goes straight to the output register if the FIFO is empty and
// port A is idle.
module regfile_wb_arb #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   input  logic [4:0]  a_reg,
   input  logic [31:0] a_data,
   output logic        a_stall,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_reg,
   input  logic [31:0] b_data,
   output logic        wen,
   output logic [4:0]  wreg,
   output logic [31:0] wdata,
   output logic [31:0] pend
);

   localparam int AGE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

   // FIFO storage. Entry 0 is always the head.
   logic [4:0]       fifo_reg  [2];
   logic [31:0]      fifo_data [2];
   logic [1:0]       count;
   logic [AGE_W-1:0] age;

   logic        b_fire;
   logic        a_sel;
   logic        head_sel;
   logic        byp_sel;
   logic        push;
   logic        sel_en;
   logic [4:0]  sel_reg;
   logic [31:0] sel_data;

   // The FIFO head loses only to a live A write, and never once it has
   // aged out. A same-cycle pop does not reopen b_ready.
   assign a_stall = !reset && (count != 2'd0) && (age >= AGE_LIMIT);
   assign b_ready = !reset && (count < 2'd2);
   assign b_fire  = b_valid && b_ready;

   // Write-source arbitration: A, then FIFO head, then (optionally) bypass.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      a_sel    = a_valid && (a_reg != 5'd0) && !a_stall;
      head_sel = !a_sel && (count != 2'd0);
      byp_sel  = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
      byp_sel  = !a_sel && (count == 2'd0) && b_fire && (b_reg != 5'd0);
`endif
      push     = b_fire && (b_reg != 5'd0) && !byp_sel;
      sel_en   = 1'b0;
      sel_reg  = 5'd0;
      sel_data = 32'd0;
      if (a_sel) begin
         sel_en   = 1'b1;
         sel_reg  = a_reg;
         sel_data = a_data;
      end else if (head_sel) begin
         sel_en   = 1'b1;
         sel_reg  = fifo_reg[0];
         sel_data = fifo_data[0];
      end else if (byp_sel) begin
         sel_en   = 1'b1;
         sel_reg  = b_reg;
         sel_data = b_data;
      end
   end

   // FIFO payload: shift on pop, write the new entry behind the survivors.
   always_ff @(posedge clk) begin
      // NOTE: payload is not reset; count alone decides which entries are
      // valid, so stale contents are never observed.
      if (head_sel && (count == 2'd2)) begin
         fifo_reg[0]  <= fifo_reg[1];
         fifo_data[0] <= fifo_data[1];
      end
      if (push) begin
         if ((count == 2'd0) || head_sel) begin
            fifo_reg[0]  <= b_reg;
            fifo_data[0] <= b_data;
         end else begin
            fifo_reg[1]  <= b_reg;
            fifo_data[1] <= b_data;
         end
      end
   end

   // FIFO occupancy and head age.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every
      // register in this block samples the pre-edge values.
      if (reset) begin
         count <= 2'd0;
         age   <= '0;
      end else begin
         case ({push, head_sel})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if ((count == 2'd0) || head_sel) begin
            age <= '0;
         end else if (a_sel) begin
            age <= age + 1'b1;
         end
      end
   end

   // Registered GPR write port. wreg and wdata hold their value when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wen   <= 1'b0;
         wreg  <= 5'd0;
         wdata <= 32'd0;
      end else begin
         wen <= sel_en;
         if (sel_en) begin
            wreg  <= sel_reg;
            wdata <= sel_data;
         end
      end
   end

   // Pending-write scoreboard: the output register plus valid FIFO entries.
   always_comb begin
      pend = 32'd0;
      if (wen) pend[wreg] = 1'b1;
      if (count != 2'd0) pend[fifo_reg[0]] = 1'b1;
      if (count == 2'd2) pend[fifo_reg[1]] = 1'b1;
      pend[0] = 1'b0;
      if (reset) pend = 32'd0;
   end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb: directed scenarios followed by random traffic. Every
// cycle is compared against a queue-based reference model of the writeback
// arbiter. Honours REGFILE_WB_BYPASS_EN in the same way as the design.
module tb_regfile_wb_arb;

   localparam int LIMIT = 3;
`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid;
   logic [4:0]  a_reg;
   logic [31:0] a_data;
   logic        a_stall;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_reg;
   logic [31:0] b_data;
   logic        wen;
   logic [4:0]  wreg;
   logic [31:0] wdata;
   logic [31:0] pend;

   regfile_wb_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_stall(a_stall),
      .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
      .wen(wen), .wreg(wreg), .wdata(wdata), .pend(pend)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: writes waiting in the buffer, in arrival order.
   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   int          m_age = 0;
   bit          m_rst = 1'b1;
   bit          m_wen = 1'b0;
   logic [4:0]  m_wreg = 5'd0;
   logic [31:0] m_wdata = 32'd0;

   function automatic bit m_stall();
      return !m_rst && (q.size() > 0) && (m_age >= LIMIT);
   endfunction

   function automatic logic [31:0] m_pend();
      logic [31:0] p = 32'd0;
      if (m_rst) return 32'd0;
      if (m_wen && m_wreg != 0) p[m_wreg] = 1'b1;
      foreach (q[i]) if (q[i].r != 0) p[q[i].r] = 1'b1;
      return p;
   endfunction

   // Advance the model across one rising edge using the current inputs.
   task automatic model_update();
      bit   a_wins, b_xfer, was_busy, popped, bypassed;
      ent_t e;
      m_rst = reset;
      if (reset) begin
         q.delete();
         m_age = 0; m_wen = 0; m_wreg = 0; m_wdata = 0;
         return;
      end
      a_wins   = a_valid && (a_reg != 0) && !m_stall();
      b_xfer   = b_valid && (q.size() < 2);
      was_busy = q.size() > 0;
      popped   = 0;
      bypassed = 0;
      if (a_wins) begin
         m_wen = 1; m_wreg = a_reg; m_wdata = a_data;
      end else if (was_busy) begin
         e = q.pop_front();
         popped = 1;
         m_wen = 1; m_wreg = e.r; m_wdata = e.d;
      end else if (BYPASS && b_xfer && b_reg != 0) begin
         bypassed = 1;
         m_wen = 1; m_wreg = b_reg; m_wdata = b_data;
      end else begin
         m_wen = 0;
      end
      if (was_busy && !popped) m_age = m_age + 1;
      else m_age = 0;
      if (b_xfer && b_reg != 0 && !bypassed) q.push_back('{r: b_reg, d: b_data});
   endtask

   task automatic model_check();
      check("wen", 32'(wen), 32'(m_wen));
      check("wreg", 32'(wreg), 32'(m_wreg));
      check("wdata", wdata, m_wdata);
      check("pend", pend, m_pend());
      check("a_stall", 32'(a_stall), 32'(m_stall()));
      check("b_ready", 32'(b_ready), 32'(!m_rst && q.size() < 2));
   endtask

   // Apply one cycle of inputs, cross the edge, compare on the falling edge.
   task automatic step(input bit rst, input bit av, input logic [4:0] ar,
                       input logic [31:0] ad, input bit bv,
                       input logic [4:0] br, input logic [31:0] bd);
      reset = rst; a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
      model_update();
      @(posedge clk);
      @(negedge clk);
      model_check();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1; a_valid = 0; a_reg = 0; a_data = 0;
      b_valid = 0; b_reg = 0; b_data = 0;

      // Reset held for two cycles, then released.
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 5'd9, 32'h55, 1, 5'd4, 32'h66);
      check("rst_wen", 32'(wen), 32'd0);
      check("rst_pend", pend, 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
      idle(1);
      check("post_rst_b_ready", 32'(b_ready), 32'd1);

      // Port A write: visible exactly one cycle later.
      step(0, 1, 5'd5, 32'h1234, 0, 0, 0);
      check("a_wen", 32'(wen), 32'd1);
      check("a_wreg", 32'(wreg), 32'd5);
      check("a_wdata", wdata, 32'h1234);
      check("a_pend5", 32'(pend[5]), 32'd1);
      idle(1);
      check("a_pend5_clr", 32'(pend[5]), 32'd0);

      // Port B write with A idle; then a discarded A write to r0.
      step(0, 0, 0, 0, 1, 5'd7, 32'hAA);
      check("b_wen_n1", 32'(wen), 32'(BYPASS));
      check("b_pend7", 32'(pend[7]), 32'd1);
      idle(1);
      check("b_wen_n2", 32'(wen), 32'(!BYPASS));
      if (!BYPASS) check("b_wdata", wdata, 32'hAA);
      step(0, 1, 5'd0, 32'hDEAD, 0, 0, 0);
      check("r0_wen", 32'(wen), 32'd0);
      idle(1);

      // Three B transfers under continuous A, running into starvation.
      step(0, 1, 5'd10, 32'h10, 1, 5'd1, 32'h101);
      step(0, 1, 5'd11, 32'h11, 1, 5'd2, 32'h102);
      check("full_b_ready", 32'(b_ready), 32'd0);
      check("full_pend1", 32'(pend[1]), 32'd1);
      check("full_pend2", 32'(pend[2]), 32'd1);
      check("age1_stall", 32'(a_stall), 32'd0);
      step(0, 1, 5'd12, 32'h12, 1, 5'd3, 32'h103);
      step(0, 1, 5'd13, 32'h13, 1, 5'd3, 32'h103);
      check("starve_stall", 32'(a_stall), 32'd1);
      step(0, 1, 5'd14, 32'h14, 1, 5'd3, 32'h103);
      check("starve_wreg", 32'(wreg), 32'd1);
      check("starve_wdata", wdata, 32'h101);
      check("starve_drop", 32'(pend[14]), 32'd0);
      check("starve_clr", 32'(a_stall), 32'd0);
      idle(4);

      // Count = 1 with simultaneous push and pop keeps FIFO order.
      step(0, 1, 5'd20, 32'h20, 1, 5'd4, 32'h104);
      step(0, 0, 0, 0, 1, 5'd6, 32'h106);
      check("pp_wreg", 32'(wreg), 32'd4);
      check("pp_b_ready", 32'(b_ready), 32'd1);
      check("pp_pend6", 32'(pend[6]), 32'd1);
      idle(1);
      check("pp_wreg2", 32'(wreg), 32'd6);
      check("pp_wdata2", wdata, 32'h106);
      idle(1);
      check("pp_drain", 32'(wen), 32'd0);

      // Reset mid-operation drops buffered writes.
      step(0, 1, 5'd21, 32'h21, 1, 5'd8, 32'h108);
      step(0, 1, 5'd22, 32'h22, 1, 5'd9, 32'h109);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(1);
      check("midrst_wen", 32'(wen), 32'd0);
      check("midrst_pend", pend, 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bit          rst, av, bv;
         logic [4:0]  ar, br;
         rst = ($urandom_range(0, 299) == 0);
         av  = ($urandom_range(0, 99) < 65);
         if (m_stall() && $urandom_range(0, 9) != 0) av = 0;
         bv  = ($urandom_range(0, 99) < 50);
         ar  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         br  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         step(rst, av, ar, $urandom, bv, br, $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
